serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/adder_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and width limits.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int MAX_WIDTH = 32;

    // Bit counter must be able to hold WIDTH itself after the final increment.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full-add cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add cell consumes one operand bit per clock, LSB first,
// producing a registered WIDTH-bit sum and carry-out after WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    import adder_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_full_adder (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    if (WIDTH == 1) begin : g_res_w1
        assign res_next = fa_sum;
    end else begin : g_res_wn
        assign res_next = {fa_sum, res_reg[WIDTH-1:1]};
    end

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        res_reg   <= '0;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    res_reg   <= res_next;
                    carry_reg <= fa_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    // Published outputs only move on the edge that consumes the top bit.
                    if (last_bit) begin
                        sum_reg  <= res_next;
                        cout_reg <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1) against an arithmetic reference.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int         checks;
    int         errors;
    logic [7:0] prev_sum;
    logic       prev_cout;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 addition with full timing and hold checks; optional mid-run disturbance.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input bit disturb);
        logic [8:0] total;
        int         lat;
        int         busy_cnt;
        int         hold_bad;
        total    = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
        a8       = av;
        b8       = bv;
        cin8     = cv;
        start8   = 1'b1;
        @(posedge clk); #1;
        start8   = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        hold_bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) begin
                lat = i;
                break;
            end
            if (busy8) busy_cnt++;
            if (sum8 !== prev_sum || cout8 !== prev_cout) hold_bad++;
            if (disturb && i == 3) begin
                start8 = 1'b1;
                a8     = 8'h00;
                b8     = 8'h00;
                cin8   = 1'b0;
            end else if (disturb && i == 4) begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        check("done_latency", 32'(lat), 32'd8);
        check("busy_cycles", 32'(busy_cnt), 32'd8);
        check("hold_in_run", 32'(hold_bad), 32'd0);
        check("sum", 32'(sum8), 32'(total[7:0]));
        check("cout", 32'(cout8), 32'(total[8]));
        $display("op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d", av, bv, cv,
                 sum8, cout8, lat);
        prev_sum  = total[7:0];
        prev_cout = total[8];
        @(posedge clk); #1;
        check("done_single", 32'(done8), 32'd0);
    endtask

    task automatic mid_reset();
        int done_cnt;
        a8     = 8'h10;
        b8     = 8'h20;
        cin8   = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) done_cnt++;
            @(posedge clk); #1;
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);
        $display("mid-run reset applied, outputs cleared");
        do_op8(8'h01, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic back_to_back();
        logic [7:0] av;
        logic [7:0] bv;
        logic       cv;
        logic [8:0] total;
        int         t;
        int         last_t;
        int         pulses;
        av     = 8'($urandom);
        bv     = 8'($urandom);
        cv     = 1'($urandom);
        a8     = av;
        b8     = bv;
        cin8   = cv;
        start8 = 1'b1;
        t      = 0;
        last_t = 0;
        pulses = 0;
        while (pulses < 3 && t < 60) begin
            @(posedge clk); #1;
            t++;
            if (done8) begin
                total = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
                check("b2b_sum", 32'(sum8), 32'(total[7:0]));
                check("b2b_cout", 32'(cout8), 32'(total[8]));
                if (pulses > 0) check("b2b_period", 32'(t - last_t), 32'd10);
                $display("b2b a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d at t=%0d", av, bv,
                         cv, sum8, cout8, t);
                last_t    = t;
                pulses++;
                prev_sum  = total[7:0];
                prev_cout = total[8];
                av        = 8'($urandom);
                bv        = 8'($urandom);
                cv        = 1'($urandom);
                a8        = av;
                b8        = bv;
                cin8      = cv;
            end
        end
        start8 = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd3);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_op1(input logic av, input logic bv, input logic cv);
        int       lat;
        logic [1:0] total;
        total  = {1'b0, av} + {1'b0, bv} + {1'b0, cv};
        a1     = av;
        b1     = bv;
        cin1   = cv;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat    = -1;
        for (int i = 0; i < 6; i++) begin
            if (done1) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        check("w1_latency", 32'(lat), 32'd1);
        check("w1_sum", 32'(sum1), 32'(total[0]));
        check("w1_cout", 32'(cout1), 32'(total[1]));
        $display("w1 a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d lat=%0d", av, bv, cv, sum1,
                 cout1, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
        rst       = 1'b1;
        start8    = 1'b0;
        a8        = 8'h00;
        b8        = 8'h00;
        cin8      = 1'b0;
        start1    = 1'b0;
        a1        = 1'b0;
        b1        = 1'b0;
        cin1      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_sum", 32'(sum8), 32'd0);
        check("reset_cout", 32'(cout8), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op8(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op8(8'h5A, 8'h3C, 1'b1, 1'b0);
        do_op8(8'h5A, 8'h3C, 1'b1, 1'b1);
        mid_reset();
        back_to_back();
        for (int n = 0; n < 16; n++) begin
            do_op8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end
        do_op1(1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 8; n++) begin
            do_op1(n[0], n[1], n[2]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
